// File: rtl/opb_cmd_master.sv
// Single-beat OPB bus master: turns one fabric read/write command into an
// OPB request/grant/select/ack sequence and returns a one-cycle response.
module opb_cmd_master #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter int C_TIMEOUT    = 16,
  parameter int C_MAX_RETRY  = 8
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0]   cmd_addr,
  input  logic [C_OPB_DWIDTH-1:0]   cmd_wdata,
  input  logic [C_OPB_DWIDTH/8-1:0] cmd_be,
  output logic                      rsp_valid,
  output logic [C_OPB_DWIDTH-1:0]   rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic                      M_request,
  input  logic                      OPB_MGrant,
  output logic                      M_select,
  output logic                      M_RNW,
  output logic [0:C_OPB_AWIDTH-1]   M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1] M_BE,
  output logic [0:C_OPB_DWIDTH-1]   M_DBus,
  output logic                      M_seqAddr,
  output logic                      M_busLock,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_xferAck,
  input  logic                      OPB_errAck,
  input  logic                      OPB_retry,
  input  logic                      OPB_toutSup
);

  localparam int BW = C_OPB_DWIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    RSP
  } state_t;

  state_t state, state_n;

  logic                    rnw_q, rnw_n;
  logic [C_OPB_AWIDTH-1:0] addr_q, addr_n;
  logic [C_OPB_DWIDTH-1:0] wdata_q, wdata_n;
  logic [BW-1:0]           be_q, be_n;
  logic [7:0]              retry_cnt, retry_n;
  logic [7:0]              tout_cnt, tout_n;

  logic                    cmd_ready_n;
  logic                    rsp_valid_n;
  logic [C_OPB_DWIDTH-1:0] rsp_rdata_n;
  logic                    rsp_err_n;
  logic                    rsp_timeout_n;
  logic                    request_n;
  logic                    select_n;
  logic                    m_rnw_n;
  logic [0:C_OPB_AWIDTH-1] abus_n;
  logic [0:BW-1]           be_bus_n;
  logic [0:C_OPB_DWIDTH-1] dbus_n;

  logic                    end_xfer;
  logic                    end_err;
  logic                    end_tout;
  logic [C_OPB_DWIDTH-1:0] end_data;
  logic                    back_req;

  assign M_seqAddr = 1'b0;
  assign M_busLock = 1'b0;

  always_comb begin
    state_n       = state;
    rnw_n         = rnw_q;
    addr_n        = addr_q;
    wdata_n       = wdata_q;
    be_n          = be_q;
    retry_n       = retry_cnt;
    tout_n        = tout_cnt;
    cmd_ready_n   = 1'b0;
    rsp_valid_n   = 1'b0;
    rsp_rdata_n   = rsp_rdata;
    rsp_err_n     = rsp_err;
    rsp_timeout_n = rsp_timeout;
    request_n     = M_request;
    select_n      = M_select;
    m_rnw_n       = M_RNW;
    abus_n        = M_ABus;
    be_bus_n      = M_BE;
    dbus_n        = M_DBus;
    end_xfer      = 1'b0;
    end_err       = 1'b0;
    end_tout      = 1'b0;
    end_data      = '0;
    back_req      = 1'b0;

    unique case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          rnw_n       = cmd_rnw;
          addr_n      = cmd_addr;
          wdata_n     = cmd_wdata;
          be_n        = cmd_be;
          retry_n     = '0;
          cmd_ready_n = 1'b0;
          request_n   = 1'b1;
          state_n     = REQ;
        end
      end
      REQ: begin
        if (OPB_MGrant) begin
          request_n = 1'b0;
          select_n  = 1'b1;
          m_rnw_n   = rnw_q;
          abus_n    = addr_q;
          be_bus_n  = be_q;
          dbus_n    = rnw_q ? '0 : wdata_q;
          tout_n    = '0;
          state_n   = XFER;
        end
      end
      XFER: begin
        if (OPB_errAck) begin
          end_xfer = 1'b1;
          end_err  = 1'b1;
        end else if (OPB_xferAck) begin
          end_xfer = 1'b1;
          end_data = rnw_q ? OPB_DBus : '0;
        end else if (OPB_retry) begin
          if (retry_cnt == 8'(C_MAX_RETRY)) begin
            end_xfer = 1'b1;
            end_err  = 1'b1;
          end else begin
            retry_n  = retry_cnt + 8'd1;
            back_req = 1'b1;
          end
        end else if (!OPB_toutSup) begin
          if (tout_cnt == 8'(C_TIMEOUT - 1)) begin
            end_xfer = 1'b1;
            end_err  = 1'b1;
            end_tout = 1'b1;
          end else begin
            tout_n = tout_cnt + 8'd1;
          end
        end
      end
      RSP: begin
        cmd_ready_n = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Leaving the data phase always releases the OR-bus on the same edge
    if (end_xfer || back_req) begin
      select_n = 1'b0;
      m_rnw_n  = 1'b0;
      abus_n   = '0;
      be_bus_n = '0;
      dbus_n   = '0;
    end
    if (back_req) begin
      request_n = 1'b1;
      state_n   = REQ;
    end
    if (end_xfer) begin
      rsp_valid_n   = 1'b1;
      rsp_rdata_n   = end_data;
      rsp_err_n     = end_err;
      rsp_timeout_n = end_tout;
      state_n       = RSP;
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state       <= IDLE;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      retry_cnt   <= '0;
      tout_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      M_request   <= 1'b0;
      M_select    <= 1'b0;
      M_RNW       <= 1'b0;
      M_ABus      <= '0;
      M_BE        <= '0;
      M_DBus      <= '0;
    end else begin
      state       <= state_n;
      rnw_q       <= rnw_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      be_q        <= be_n;
      retry_cnt   <= retry_n;
      tout_cnt    <= tout_n;
      cmd_ready   <= cmd_ready_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_err     <= rsp_err_n;
      rsp_timeout <= rsp_timeout_n;
      M_request   <= request_n;
      M_select    <= select_n;
      M_RNW       <= m_rnw_n;
      M_ABus      <= abus_n;
      M_BE        <= be_bus_n;
      M_DBus      <= dbus_n;
    end
  end

endmodule

// File: tb/tb_opb_cmd_master.sv
// Bench for opb_cmd_master: acts as arbiter and slave, predicts each
// response from a transaction-level model of the OPB handshake rules.
module tb_opb_cmd_master;

  localparam int TOUT = 16;
  localparam int MAXR = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rnw = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        m_request;
  logic        grant = 1'b0;
  logic        m_select;
  logic        m_rnw;
  logic [0:31] m_abus;
  logic [0:3]  m_be;
  logic [0:31] m_dbus;
  logic        m_seqaddr;
  logic        m_buslock;
  logic [0:31] opb_dbus = '0;
  logic        xfer_ack = 1'b0;
  logic        err_ack = 1'b0;
  logic        retry = 1'b0;
  logic        tout_sup = 1'b0;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  opb_cmd_master #(
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_TIMEOUT   (TOUT),
    .C_MAX_RETRY (MAXR)
  ) dut (
    .OPB_Clk    (clk),
    .OPB_Rst    (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rnw    (cmd_rnw),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_be     (cmd_be),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .M_request  (m_request),
    .OPB_MGrant (grant),
    .M_select   (m_select),
    .M_RNW      (m_rnw),
    .M_ABus     (m_abus),
    .M_BE       (m_be),
    .M_DBus     (m_dbus),
    .M_seqAddr  (m_seqaddr),
    .M_busLock  (m_buslock),
    .OPB_DBus   (opb_dbus),
    .OPB_xferAck(xfer_ack),
    .OPB_errAck (err_ack),
    .OPB_retry  (retry),
    .OPB_toutSup(tout_sup)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    else
      passed++;
  endtask

  task automatic idle_slave();
    grant    = 1'b0;
    xfer_ack = 1'b0;
    err_ack  = 1'b0;
    retry    = 1'b0;
    tout_sup = 1'b0;
    opb_dbus = '0;
  endtask

  task automatic send_cmd(input logic rnw, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be);
    int w;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_be    = be;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_be    = 4'($urandom);
  endtask

  // oc: 0 ack, 1 errAck+xferAck, 2 no ack (timeout), 3 errAck only.
  // g grant wait, r retries, dr retry position, s toutSup cycles, d ack pos.
  task automatic run_txn(input string nm, input logic rnw,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int g, input int r,
                         input int dr, input int oc, input int s,
                         input int d, input logic [31:0] rdv);
    int       e_nph, e_sel, e_lat, nret, fin;
    logic     e_err, e_to;
    logic [31:0] e_rd;
    int       lat, nph, sel, rsp_n, k, wcnt, bad, f_lat;
    logic     prev_req, done, g_err, g_to;
    logic [31:0] g_rd;

    if (r > MAXR) begin
      nret = MAXR;
      fin  = dr + 1;
      e_err = 1'b1; e_to = 1'b0; e_rd = '0;
    end else begin
      nret = r;
      e_to = 1'b0; e_rd = '0;
      case (oc)
        0: begin fin = d + 1; e_err = 1'b0; e_rd = rnw ? rdv : 32'h0; end
        1, 3: begin fin = d + 1; e_err = 1'b1; end
        default: begin fin = s + TOUT; e_err = 1'b1; e_to = 1'b1; end
      endcase
    end
    e_nph = nret + 1;
    e_sel = nret * (dr + 1) + fin;
    e_lat = e_nph * (g + 1) + e_sel + 1;

    send_cmd(rnw, addr, wd, be);
    lat = 0; nph = 0; sel = 0; rsp_n = 0; k = 0; wcnt = 0; bad = 0;
    f_lat = 0; prev_req = 1'b0; done = 1'b0;
    g_err = 1'b0; g_to = 1'b0; g_rd = '0;
    while (!done && lat < 3000) begin
      lat++;
      if (m_select) begin
        sel++;
        if (m_abus !== addr || m_be !== be || m_rnw !== rnw ||
            m_dbus !== (rnw ? 32'h0 : wd)) bad++;
      end else if (m_abus !== 0 || m_be !== 0 || m_dbus !== 0) begin
        bad++;
      end
      if (m_seqaddr || m_buslock) bad++;
      if (m_request && !prev_req) nph++;
      prev_req = m_request;
      if (rsp_valid) begin
        rsp_n++;
        if (rsp_n == 1) begin
          f_lat = lat;
          g_err = rsp_err; g_to = rsp_timeout; g_rd = rsp_rdata;
        end
      end else if (rsp_n > 0) begin
        done = 1'b1;
      end
      if (!done && cmd_ready) bad++;
      if (!done) begin
        grant = m_request && (wcnt == g);
        wcnt  = m_request ? wcnt + 1 : 0;
        xfer_ack = 1'b0; err_ack = 1'b0; retry = 1'b0; tout_sup = 1'b0;
        opb_dbus = $urandom;
        if (m_select) begin
          if (nph - 1 < r) begin
            retry = (k == dr);
          end else begin
            tout_sup = (k < s);
            if (k == d && oc != 2) begin
              xfer_ack = (oc != 3);
              err_ack  = (oc == 1 || oc == 3);
              opb_dbus = rdv;
            end
          end
          k++;
        end else begin
          k = 0;
        end
        @(negedge clk);
      end
    end
    idle_slave();
    chk({nm, ".done"}, done, 1);
    chk({nm, ".ready"}, cmd_ready, 1);
    chk({nm, ".err"}, g_err, e_err);
    chk({nm, ".tout"}, g_to, e_to);
    chk({nm, ".rdata"}, g_rd, e_rd);
    chk({nm, ".reqs"}, nph, e_nph);
    chk({nm, ".sel"}, sel, e_sel);
    chk({nm, ".lat"}, f_lat, e_lat);
    chk({nm, ".pulses"}, rsp_n, 1);
    chk({nm, ".bus"}, bad, 0);
    chk({nm, ".hold"}, rsp_err, e_err);
  endtask

  initial begin
    int n_rsp, n_sel;
    idle_slave();
    repeat (2) @(negedge clk);
    chk("rst.ready", cmd_ready, 0);
    chk("rst.req", m_request, 0);
    chk("rst.sel", m_select, 0);
    chk("rst.rsp", rsp_valid, 0);
    chk("rst.abus", m_abus, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready1", cmd_ready, 1);

    run_txn("wr", 1'b0, 32'h010B0004, 32'hDEADBEEF, 4'hF,
            1, 0, 0, 0, 0, 2, 32'h0);
    run_txn("rd", 1'b1, 32'h010B0000, 32'h0, 4'hF,
            0, 0, 0, 0, 0, 0, 32'h12345678);
    run_txn("tmo", 1'b1, 32'h010B0008, 32'h0, 4'hF,
            0, 0, 0, 2, 0, 0, 32'h0);
    run_txn("sup", 1'b1, 32'h010B000C, 32'h0, 4'h3,
            2, 0, 0, 0, 40, 40, 32'hCAFEF00D);
    run_txn("errack", 1'b1, 32'h010B0010, 32'h0, 4'hF,
            0, 0, 0, 1, 0, 1, 32'hA5A5A5A5);
    run_txn("rty3", 1'b0, 32'h010B0014, 32'h11223344, 4'hC,
            1, 3, 1, 0, 0, 0, 32'h0);
    run_txn("rty9", 1'b1, 32'h010B0018, 32'h0, 4'hF,
            0, 9, 0, 0, 0, 0, 32'h55AA55AA);

    send_cmd(1'b1, 32'h010B001C, 32'h0, 4'hF);
    n_sel = 0;
    for (int i = 0; i < 20 && n_sel < 4; i++) begin
      grant = m_request;
      if (m_select) n_sel++;
      @(negedge clk);
    end
    grant = 1'b0;
    chk("arst.pre_sel", m_select, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst.sel", m_select, 0);
    chk("arst.req", m_request, 0);
    chk("arst.ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_rsp = 0;
    n_sel = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
      if (m_select || m_request) n_sel++;
    end
    chk("arst.norsp", n_rsp, 0);
    chk("arst.idle", n_sel, 0);
    run_txn("post", 1'b1, 32'h010B0000, 32'h0, 4'hF,
            0, 0, 0, 0, 0, 0, 32'h87654321);

    for (int t = 0; t < 40; t++) begin
      int g, r, dr, oc, s, d;
      g  = $urandom_range(0, 3);
      r  = ($urandom_range(0, 5) == 0) ? $urandom_range(9, 10)
                                       : $urandom_range(0, 3);
      dr = $urandom_range(0, 2);
      oc = $urandom_range(0, 3);
      s  = ($urandom_range(0, 4) == 0) ? 30 : $urandom_range(0, 5);
      d  = s + $urandom_range(0, 10);
      run_txn("rnd", 1'($urandom), $urandom, $urandom, 4'($urandom),
              g, r, dr, oc, s, d, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
